// File: rtl/reg_scoreboard_pkg.sv
// Shared widths and types for the long-latency register scoreboard.
package reg_scoreboard_pkg;

   localparam int REG_W = 5;
   localparam int NREGS = 32;
   localparam int CNT_W = 4;

   typedef logic [REG_W-1:0] reg_t;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam reg_t X0 = 5'd0;

endpackage

// File: rtl/reg_scoreboard_sb_file.sv
// One 32-entry pending-bit file with a set port, a clear port and
// combinational read ports for the ID sources, ID destination and writeback.
module sb_file
   import reg_scoreboard_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  reg_t set_addr,
   input  logic clr,
   input  reg_t clr_addr,
   input  reg_t rs1,
   input  reg_t rs2,
   input  reg_t rs3,
   input  reg_t rd,
   output logic rs1_pend,
   output logic rs2_pend,
   output logic rs3_pend,
   output logic rd_pend,
   output logic clr_pend
);

   logic [NREGS-1:0] pend;

   // set is applied after clear so it wins on the same register
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
      end else begin
         if (clr) pend[clr_addr] <= 1'b0;
         if (set) pend[set_addr] <= 1'b1;
      end
   end

   assign rs1_pend = pend[rs1];
   assign rs2_pend = pend[rs2];
   assign rs3_pend = pend[rs3];
   assign rd_pend  = pend[rd];
   assign clr_pend = pend[clr_addr];

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-register scoreboard for long-latency ops: RAW/WAW/full stall,
// outstanding-op counter and sticky stray-writeback error.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int FLOAT   = 0,
   parameter int MAX_OUT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       issue_valid,
   input  reg_t       issue_rd,
   input  logic       issue_fp,
   input  reg_t       rs1_id,
   input  reg_t       rs2_id,
   input  reg_t       rs3_id,
   input  reg_t       rd_id,
   input  logic [2:0] use_rs,
   input  logic [2:0] float_read,
   input  logic       rd_fp_id,
   input  logic       rd_we_id,
   input  logic       wb_valid,
   input  reg_t       wb_rd,
   input  logic       wb_fp,
   output logic       sb_stall,
   output logic       sb_full,
   output logic       sb_err
);

   localparam bit HAS_FP = (FLOAT != 0);

   cnt_t count;
   logic acc;
   logic i_fp, w_fp, d_fp;
   logic [2:0] use_eff, fr_eff;
   reg_t src [3];

   assign i_fp    = HAS_FP && issue_fp;
   assign w_fp    = HAS_FP && wb_fp;
   assign d_fp    = HAS_FP && rd_fp_id;
   assign use_eff = HAS_FP ? use_rs : {1'b0, use_rs[1:0]};
   assign fr_eff  = HAS_FP ? float_read : 3'b000;

   assign src[0] = rs1_id;
   assign src[1] = rs2_id;
   assign src[2] = rs3_id;

   logic [2:0] int_src, fp_src;
   logic int_rd, fp_rd, int_clr, fp_clr;

   sb_file u_int (
      .clk      (clk),
      .rst      (rst),
      .set      (acc && !i_fp && issue_rd != X0),
      .set_addr (issue_rd),
      .clr      (wb_valid && !w_fp),
      .clr_addr (wb_rd),
      .rs1      (rs1_id),
      .rs2      (rs2_id),
      .rs3      (rs3_id),
      .rd       (rd_id),
      .rs1_pend (int_src[0]),
      .rs2_pend (int_src[1]),
      .rs3_pend (int_src[2]),
      .rd_pend  (int_rd),
      .clr_pend (int_clr)
   );

   generate
      if (HAS_FP) begin : g_fp
         sb_file u_fp (
            .clk      (clk),
            .rst      (rst),
            .set      (acc && i_fp),
            .set_addr (issue_rd),
            .clr      (wb_valid && w_fp),
            .clr_addr (wb_rd),
            .rs1      (rs1_id),
            .rs2      (rs2_id),
            .rs3      (rs3_id),
            .rd       (rd_id),
            .rs1_pend (fp_src[0]),
            .rs2_pend (fp_src[1]),
            .rs3_pend (fp_src[2]),
            .rd_pend  (fp_rd),
            .clr_pend (fp_clr)
         );
      end else begin : g_no_fp
         assign fp_src = 3'b000;
         assign fp_rd  = 1'b0;
         assign fp_clr = 1'b0;
      end
   endgenerate

   // integer x0 is never a hazard; FP f0 is tracked normally
   logic raw, waw, full_stall, rd_pend, wb_pend;

   always_comb begin
      raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (use_eff[i]) begin
            if (fr_eff[i]) begin
               raw = raw || (fp_src[i] &&
                     !(wb_valid && wb_rd == src[i] && w_fp));
            end else begin
               raw = raw || (int_src[i] && src[i] != X0 &&
                     !(wb_valid && wb_rd == src[i] && !w_fp));
            end
         end
      end
   end

   assign rd_pend = d_fp ? fp_rd : (int_rd && rd_id != X0);
   assign waw = rd_we_id && rd_pend &&
                !(wb_valid && wb_rd == rd_id && w_fp == d_fp);

   assign sb_full    = (count == cnt_t'(MAX_OUT));
   assign full_stall = issue_valid && sb_full && !wb_valid;
   assign sb_stall   = raw || waw || full_stall;
   assign acc        = issue_valid && !sb_stall;
   assign wb_pend    = w_fp ? fp_clr : int_clr;

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         sb_err <= 1'b0;
      end else begin
         if (wb_valid && (!wb_pend || count == '0)) sb_err <= 1'b1;
         case ({acc, wb_valid})
            2'b10:   count <= count + cnt_t'(1);
            2'b01:   if (count != '0) count <= count - cnt_t'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
